// File: rtl/if_fetch_queue_pkg.sv
// Shared defaults and constants for the instruction-fetch queue slice.
// The fetch PC, its queue and the decode-side drain all take their sizes from here.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W   = 32;
  localparam int unsigned FETCH_INST_W   = 32;
  localparam int unsigned FETCH_DEPTH    = 4;
  localparam int unsigned FETCH_PC_STEP  = 4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  // Bubble presented to decode when the queue is empty
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  function automatic int unsigned fetch_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus: EXE redirect, decode freeze, instruction memory and queue head.
// master = fetch stage, slave = surrounding pipeline / memory.
interface if_fetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = 3
);

  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;
  logic              freeze;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CNT_W-1:0]  count;

  modport master (
    input  br_taken, br_addr, freeze, imem_data,
    output imem_addr, out_valid, out_pc, out_inst, count
  );

  modport slave (
    output br_taken, br_addr, freeze, imem_data,
    input  imem_addr, out_valid, out_pc, out_inst, count
  );

endinterface

// File: rtl/if_fetch_queue_fifo.sv
// Circular {pc, inst} buffer with push/pop/clear; pointers and count reset, storage does not.
// Clear wins over push and pop; pop on empty and push on full-without-pop are ignored.
module fetch_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [INST_W-1:0] wr_inst,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [INST_W-1:0] rd_inst,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign rd_pc   = mem_pc[head];
  assign rd_inst = mem_inst[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop_ok)  head <= head + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data path carries no reset; stale entries are never visible because count gates them
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem_pc[tail]   <= wr_pc;
      mem_inst[tail] <= wr_inst;
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue drained by decode under freeze.
// A taken branch flushes the queue and redirects fetch_pc; it overrides freeze.
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       INST_W   = FETCH_INST_W,
  parameter int unsigned       DEPTH    = FETCH_DEPTH,
  parameter int unsigned       PC_STEP  = FETCH_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  if_fetch_queue_if.master    bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] next_seq_pc;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;

  assign next_seq_pc = fetch_pc + ADDR_W'(PC_STEP);

  // Redirect blocks both sides; a full queue still accepts a word when the head leaves
  assign pop  = ~fifo_empty & ~bus.freeze & ~bus.br_taken;
  assign push = ~bus.br_taken & (~fifo_full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (bus.br_taken) begin
      fetch_pc <= bus.br_addr;
    end else if (push) begin
      fetch_pc <= next_seq_pc;
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .clear   (bus.br_taken),
    .wr_pc   (next_seq_pc),
    .wr_inst (bus.imem_data),
    .rd_pc   (head_pc),
    .rd_inst (head_inst),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign bus.imem_addr = fetch_pc;
  assign bus.count     = fifo_count;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_pc    = fifo_empty ? '0 : head_pc;
  assign bus.out_inst  = fifo_empty ? INST_W'(NOP_INST) : head_inst;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a queue-level reference model tracks expected entries,
// a monitor compares the DUT head/count/fetch address after every edge.
module tb_if_fetch_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned STEP   = 4;
  localparam int unsigned CNT_W  = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   checking = 1'b0;

  entry_t            exp_q[$];
  logic [ADDR_W-1:0] model_pc;

  if_fetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .CNT_W(CNT_W)) bus ();

  if_fetch_queue #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .PC_STEP(STEP), .RESET_PC('0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] tag(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  assign bus.imem_data = tag(bus.imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of fetched words; pop first, then refill if there is room
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      model_pc = '0;
    end else if (bus.br_taken) begin
      exp_q.delete();
      model_pc = bus.br_addr;
    end else begin
      if (exp_q.size() > 0 && !bus.freeze) void'(exp_q.pop_front());
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back('{pc: model_pc + STEP, inst: tag(model_pc)});
        model_pc = model_pc + STEP;
      end
    end
  end

  // Monitor
  always begin
    @(posedge clk);
    #1;
    if (checking) begin
      chk("count", 64'(bus.count), 64'(exp_q.size()));
      chk("imem_addr", 64'(bus.imem_addr), 64'(model_pc));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("out_pc", 64'(bus.out_pc), 64'(exp_q[0].pc));
        chk("out_inst", 64'(bus.out_inst), 64'(exp_q[0].inst));
      end else begin
        chk("bubble_pc", 64'(bus.out_pc), 64'd0);
        chk("bubble_inst", 64'(bus.out_inst), 64'd0);
      end
    end
  end

  task automatic step(input logic f, input logic b, input logic [ADDR_W-1:0] a);
    @(negedge clk);
    bus.freeze   = f;
    bus.br_taken = b;
    bus.br_addr  = a;
  endtask

  initial begin
    bus.freeze   = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_addr  = '0;
    #2;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_imem", 64'(bus.imem_addr), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    // Free-running fetch
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    chk("steady_count", 64'(bus.count), 64'd1);

    // Freeze long enough to fill, then release
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    chk("full_count", 64'(bus.count), 64'(DEPTH));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);

    // Full queue with a single consume cycle
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("pushpop_count", 64'(bus.count), 64'(DEPTH));
    step(1'b1, 1'b0, '0);

    // Redirect while frozen
    step(1'b1, 1'b1, 32'h0000_0100);
    step(1'b1, 1'b0, '0);
    chk("br_count", 64'(bus.count), 64'd0);
    chk("br_imem", 64'(bus.imem_addr), 64'h100);
    step(1'b0, 1'b0, '0);
    chk("br_target_pc", 64'(bus.out_pc), 64'h104);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);

    // Address wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, '0);
    chk("wrap_imem", 64'(bus.imem_addr), 64'hFFFF_FFFC);
    step(1'b0, 1'b0, '0);
    chk("wrap_out_pc", 64'(bus.out_pc), 64'h0);
    chk("wrap_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);

    // Randomized freeze / redirect mix
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0),
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    // Asynchronous reset between edges
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_pc", 64'(bus.out_pc), 64'd0);
    chk("arst_inst", 64'(bus.out_inst), 64'd0);
    chk("arst_imem", 64'(bus.imem_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.freeze = 1'b0;
    step(1'b0, 1'b0, '0);
    chk("restart_pc", 64'(bus.out_pc), 64'h4);
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 9) < 3), ($urandom_range(0, 29) == 0),
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
